wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone B3 arbiter that shares the main RAM port between the OR1200 instruction bus (master 0) and the OR1200 data bus (master 1).
- Grants one master for a whole cycle (cyc high), including incrementing and wrapping bursts (cti/bte passed through).
- Round-robin on contention, with an optional fixed data-bus priority.
- A response watchdog terminates hung transfers with err.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_arb_watchdog.sv | 55 +++++
 rtl/wb_arbiter_2m.sv | 159 +++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared state encoding and Wishbone cycle-type constants for the
//             two-master Wishbone arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G0    = 2'd1,
        G1    = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
// ============================================================================
//  Module   : wb_arb_watchdog
//  Purpose  : Counts strobed cycles without a slave response and flags the
//             cycle in which the count reaches TIMEOUT-1.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arb_watchdog #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_wdog;
            assign unused_wdog = ^{clk_i, rst_i, clr_i, en_i};
            assign timeout_o   = 1'b0;
        end else begin : g_on
            localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

            logic [TW-1:0] cnt_q;
            logic [TW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // A response in the threshold cycle wins over the timeout.
            assign timeout_o = en_i & ~clr_i & (cnt_q == LIMIT);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
// ============================================================================
//  Module   : wb_arbiter_2m
//  Purpose  : Two-master / one-slave Wishbone B3 arbiter with round-robin or
//             fixed data-bus priority and a response watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DATA_PRIO = 0,
    parameter int TIMEOUT   = 1024,
    parameter int TW        = 11
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wb_m0_adr_i,
    input  logic [DW-1:0]   wb_m0_dat_i,
    input  logic [DW/8-1:0] wb_m0_sel_i,
    input  logic            wb_m0_we_i,
    input  logic            wb_m0_cyc_i,
    input  logic            wb_m0_stb_i,
    input  logic [2:0]      wb_m0_cti_i,
    input  logic [1:0]      wb_m0_bte_i,
    output logic [DW-1:0]   wb_m0_dat_o,
    output logic            wb_m0_ack_o,
    output logic            wb_m0_err_o,
    output logic            wb_m0_rty_o,
    input  logic [AW-1:0]   wb_m1_adr_i,
    input  logic [DW-1:0]   wb_m1_dat_i,
    input  logic [DW/8-1:0] wb_m1_sel_i,
    input  logic            wb_m1_we_i,
    input  logic            wb_m1_cyc_i,
    input  logic            wb_m1_stb_i,
    input  logic [2:0]      wb_m1_cti_i,
    input  logic [1:0]      wb_m1_bte_i,
    output logic [DW-1:0]   wb_m1_dat_o,
    output logic            wb_m1_ack_o,
    output logic            wb_m1_err_o,
    output logic            wb_m1_rty_o,
    output logic [AW-1:0]   wb_s_adr_o,
    output logic [DW-1:0]   wb_s_dat_o,
    output logic [DW/8-1:0] wb_s_sel_o,
    output logic            wb_s_we_o,
    output logic            wb_s_cyc_o,
    output logic            wb_s_stb_o,
    output logic [2:0]      wb_s_cti_o,
    output logic [1:0]      wb_s_bte_o,
    input  logic [DW-1:0]   wb_s_dat_i,
    input  logic            wb_s_ack_i,
    input  logic            wb_s_err_i,
    input  logic            wb_s_rty_i,
    output logic [1:0]      grant_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;       // 1 = master 1 held the last grant
    logic       granted, sel_m1, s_resp, timeout;
    logic       ack_g, err_g, rty_g;

    assign granted = (state_q == G0) || (state_q == G1);
    assign sel_m1  = (state_q == G1);
    assign s_resp  = wb_s_ack_i | wb_s_err_i | wb_s_rty_i;
    assign grant_o = {state_q == G1, state_q == G0};

    assign wb_s_adr_o = granted ? (sel_m1 ? wb_m1_adr_i : wb_m0_adr_i) : '0;
    assign wb_s_dat_o = granted ? (sel_m1 ? wb_m1_dat_i : wb_m0_dat_i) : '0;
    assign wb_s_sel_o = granted ? (sel_m1 ? wb_m1_sel_i : wb_m0_sel_i) : '0;
    assign wb_s_we_o  = granted & (sel_m1 ? wb_m1_we_i  : wb_m0_we_i);
    assign wb_s_cyc_o = granted & (sel_m1 ? wb_m1_cyc_i : wb_m0_cyc_i);
    assign wb_s_stb_o = granted & (sel_m1 ? wb_m1_stb_i : wb_m0_stb_i);
    assign wb_s_cti_o = granted ? (sel_m1 ? wb_m1_cti_i : wb_m0_cti_i) : '0;
    assign wb_s_bte_o = granted ? (sel_m1 ? wb_m1_bte_i : wb_m0_bte_i) : '0;

    // The watchdog's own err replaces any slave response in its pulse cycle.
    assign ack_g = granted & wb_s_ack_i & ~timeout;
    assign err_g = granted & (wb_s_err_i | timeout);
    assign rty_g = granted & wb_s_rty_i & ~timeout;

    assign wb_m0_ack_o = ack_g & ~sel_m1;
    assign wb_m0_err_o = err_g & ~sel_m1;
    assign wb_m0_rty_o = rty_g & ~sel_m1;
    assign wb_m1_ack_o = ack_g & sel_m1;
    assign wb_m1_err_o = err_g & sel_m1;
    assign wb_m1_rty_o = rty_g & sel_m1;
    assign wb_m0_dat_o = wb_s_dat_i;
    assign wb_m1_dat_o = wb_s_dat_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wdog (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (s_resp | ~granted),
        .en_i      (wb_s_cyc_o & wb_s_stb_o),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (wb_m0_cyc_i && wb_m1_cyc_i) begin
                    if ((DATA_PRIO != 0) || !last_q) begin
                        state_d = G1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = G0;
                        last_d  = 1'b0;
                    end
                end else if (wb_m0_cyc_i) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (wb_m1_cyc_i) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0: begin
                if (timeout) begin
                    state_d = DRAIN;
                end else if (!wb_m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (timeout) begin
                    state_d = DRAIN;
                end else if (!wb_m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!(last_q ? wb_m1_cyc_i : wb_m0_cyc_i)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// ============================================================================
//  Module   : tb_wb_arbiter_2m
//  Purpose  : Self-checking bench for wb_arbiter_2m (round-robin and data
//             priority instances driven by the same stimulus).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter_2m;
    import wb_arb_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_bte [2];
    logic [31:0] s_dat_i;
    logic        s_ack, s_err, s_rty;

    logic [31:0] o_m0_dat [2];
    logic [31:0] o_m1_dat [2];
    logic        o_m0_ack [2], o_m0_err [2], o_m0_rty [2];
    logic        o_m1_ack [2], o_m1_err [2], o_m1_rty [2];
    logic [31:0] o_s_adr [2];
    logic [31:0] o_s_dat [2];
    logic [3:0]  o_s_sel [2];
    logic        o_s_we [2], o_s_cyc [2], o_s_stb [2];
    logic [2:0]  o_s_cti [2];
    logic [1:0]  o_s_bte [2];
    logic [1:0]  o_grant [2];

    // Instance 0: round-robin; instance 1: data-bus priority.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        wb_arbiter_2m #(
            .AW(32), .DW(32), .DATA_PRIO(k), .TIMEOUT(TO), .TW(11)
        ) u_dut (
            .wb_clk_i   (clk),          .wb_rst_i   (rst),
            .wb_m0_adr_i(m_adr[0]),     .wb_m0_dat_i(m_dat[0]),
            .wb_m0_sel_i(m_sel[0]),     .wb_m0_we_i (m_we[0]),
            .wb_m0_cyc_i(m_cyc[0]),     .wb_m0_stb_i(m_stb[0]),
            .wb_m0_cti_i(m_cti[0]),     .wb_m0_bte_i(m_bte[0]),
            .wb_m0_dat_o(o_m0_dat[k]),  .wb_m0_ack_o(o_m0_ack[k]),
            .wb_m0_err_o(o_m0_err[k]),  .wb_m0_rty_o(o_m0_rty[k]),
            .wb_m1_adr_i(m_adr[1]),     .wb_m1_dat_i(m_dat[1]),
            .wb_m1_sel_i(m_sel[1]),     .wb_m1_we_i (m_we[1]),
            .wb_m1_cyc_i(m_cyc[1]),     .wb_m1_stb_i(m_stb[1]),
            .wb_m1_cti_i(m_cti[1]),     .wb_m1_bte_i(m_bte[1]),
            .wb_m1_dat_o(o_m1_dat[k]),  .wb_m1_ack_o(o_m1_ack[k]),
            .wb_m1_err_o(o_m1_err[k]),  .wb_m1_rty_o(o_m1_rty[k]),
            .wb_s_adr_o (o_s_adr[k]),   .wb_s_dat_o (o_s_dat[k]),
            .wb_s_sel_o (o_s_sel[k]),   .wb_s_we_o  (o_s_we[k]),
            .wb_s_cyc_o (o_s_cyc[k]),   .wb_s_stb_o (o_s_stb[k]),
            .wb_s_cti_o (o_s_cti[k]),   .wb_s_bte_o (o_s_bte[k]),
            .wb_s_dat_i (s_dat_i),      .wb_s_ack_i (s_ack),
            .wb_s_err_i (s_err),        .wb_s_rty_i (s_rty),
            .grant_o    (o_grant[k])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus, whether it is being drained after
    // a timeout, who won last, and how many unanswered strobes so far.
    // ------------------------------------------------------------------
    int own  [2] = '{0, 0};      // 0 none, 1 master0, 2 master1
    bit drn  [2] = '{0, 0};
    int prv  [2] = '{1, 1};
    int wd   [2] = '{0, 0};
    int win;

    function automatic bit m_has(int k);
        return (own[k] != 0) && !drn[k];
    endfunction

    function automatic bit fire_f(int k);
        int m;
        m = own[k] - 1;
        if (!m_has(k)) return 1'b0;
        return m_cyc[m] && m_stb[m] && !(s_ack || s_err || s_rty) && (wd[k] == TO - 1);
    endfunction

    function automatic logic [191:0] model_out(int k);
        logic [1:0]  gr;
        logic        cyc, stb, we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic [31:0] adr, dat;
        logic [2:0]  rsp;
        logic [5:0]  r;
        int          m;
        m   = (own[k] == 2) ? 1 : 0;
        gr  = 2'b00; cyc = 0; stb = 0; we = 0; cti = 0; bte = 0; sel = 0;
        adr = 0; dat = 0; r = 0;
        if (m_has(k)) begin
            gr  = (m == 1) ? 2'b10 : 2'b01;
            cyc = m_cyc[m]; stb = m_stb[m]; we = m_we[m];
            cti = m_cti[m]; bte = m_bte[m]; sel = m_sel[m];
            adr = m_adr[m]; dat = m_dat[m];
            rsp = {s_ack && !fire_f(k), s_err || fire_f(k), s_rty && !fire_f(k)};
            r   = (m == 1) ? {3'b000, rsp} : {rsp, 3'b000};
        end
        return {gr, cyc, stb, we, cti, bte, sel, r, adr, dat, s_dat_i, s_dat_i};
    endfunction

    function automatic logic [191:0] dut_out(int k);
        return {o_grant[k], o_s_cyc[k], o_s_stb[k], o_s_we[k], o_s_cti[k], o_s_bte[k],
                o_s_sel[k], o_m0_ack[k], o_m0_err[k], o_m0_rty[k],
                o_m1_ack[k], o_m1_err[k], o_m1_rty[k],
                o_s_adr[k], o_s_dat[k], o_m0_dat[k], o_m1_dat[k]};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                own[k] <= 0; drn[k] <= 0; prv[k] <= 1; wd[k] <= 0;
            end else if (own[k] == 0) begin
                if (m_cyc[0] || m_cyc[1]) begin
                    if (m_cyc[0] && m_cyc[1]) win = (k == 1) ? 1 : 1 - prv[k];
                    else                      win = m_cyc[1] ? 1 : 0;
                    own[k] <= win + 1;
                    prv[k] <= win;
                    wd[k]  <= 0;
                end
            end else if (drn[k]) begin
                if (!m_cyc[own[k]-1]) begin
                    own[k] <= 0; drn[k] <= 0;
                end
            end else begin
                if (fire_f(k))               drn[k] <= 1;
                else if (!m_cyc[own[k]-1])   own[k] <= 0;
                if (s_ack || s_err || s_rty)                 wd[k] <= 0;
                else if (m_cyc[own[k]-1] && m_stb[own[k]-1]) wd[k] <= wd[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_dut0", dut_out(0), model_out(0));
        chk("model_dut1", dut_out(1), model_out(1));
    end

    // ------------------------------------------------------------------
    typedef struct {
        logic       c0, c1, ack;
        logic [1:0] g0, g1;
        logic       a0, a1;
    } vec_t;
    vec_t tbl [11];

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[m] = cyc; m_stb[m] = cyc; m_adr[m] = adr; m_cti[m] = cti;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = 0; m_dat[m] = 0; m_sel[m] = 4'hf; m_we[m] = 0;
            m_cyc[m] = 0; m_stb[m] = 0; m_cti[m] = CTI_CLASSIC; m_bte[m] = 0;
        end
        s_dat_i = 32'hDEADBEEF; s_ack = 0; s_err = 0; s_rty = 0;

        tbl[0]  = '{1, 1, 0, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{1, 1, 0, 2'b01, 2'b10, 0, 0};
        tbl[2]  = '{1, 1, 1, 2'b01, 2'b10, 1, 0};
        tbl[3]  = '{0, 1, 0, 2'b01, 2'b10, 0, 0};
        tbl[4]  = '{0, 1, 0, 2'b00, 2'b10, 0, 0};
        tbl[5]  = '{0, 1, 1, 2'b10, 2'b10, 0, 1};
        tbl[6]  = '{1, 0, 0, 2'b10, 2'b10, 0, 0};
        tbl[7]  = '{1, 1, 0, 2'b00, 2'b00, 0, 0};
        tbl[8]  = '{1, 1, 0, 2'b01, 2'b10, 0, 0};
        tbl[9]  = '{0, 0, 0, 2'b01, 2'b10, 0, 0};
        tbl[10] = '{0, 0, 0, 2'b00, 2'b00, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", o_grant[0], 2'b00);
        chk("rst_scyc", {o_s_cyc[0], o_s_stb[0], o_s_adr[0]}, 0);
        chk("rst_resp", {o_m0_ack[0], o_m0_err[0], o_m1_ack[0], o_m1_err[0]}, 0);
        adv();
        rst = 0;

        // Contention / round-robin / priority table.
        for (int i = 0; i < 11; i++) begin
            drive_m(0, tbl[i].c0, 32'h100, CTI_CLASSIC);
            drive_m(1, tbl[i].c1, 32'h200, CTI_CLASSIC);
            s_ack = tbl[i].ack;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant_rr", i), o_grant[0], tbl[i].g0);
            chk($sformatf("tbl%0d_grant_prio", i), o_grant[1], tbl[i].g1);
            chk($sformatf("tbl%0d_acks", i), {o_m0_ack[0], o_m1_ack[0]}, {tbl[i].a0, tbl[i].a1});
            if (i == 2) begin
                chk("read_dat", o_m0_dat[0], 32'hDEADBEEF);
                chk("read_adr", o_s_adr[0], 32'h100);
            end
            adv();
        end
        s_ack = 0;

        // Atomic 4-beat INC burst from m0 while m1 waits.
        drive_m(0, 1, 32'h300, CTI_INC);
        adv();
        m_cyc[1] = 1; m_stb[1] = 1;
        for (int b = 0; b < 4; b++) begin
            drive_m(0, 1, 32'h300 + 32'(4 * b), (b == 3) ? CTI_EOB : CTI_INC);
            s_ack = 1;
            @(negedge clk);
            chk($sformatf("burst%0d", b), {o_grant[0], o_m0_ack[0], o_m1_ack[0], o_s_cti[0]},
                {2'b01, 1'b1, 1'b0, (b == 3) ? CTI_EOB : CTI_INC});
            adv();
        end
        drive_m(0, 0, 32'h0, CTI_CLASSIC);
        s_ack = 0;
        @(negedge clk); chk("burst_drop", {o_grant[0], o_s_cyc[0]}, {2'b01, 1'b0}); adv();
        @(negedge clk); chk("burst_gap", o_grant[0], 2'b00); adv();
        @(negedge clk); chk("burst_next", o_grant[0], 2'b10); adv();
        drive_m(1, 0, 32'h0, CTI_CLASSIC);
        repeat (2) adv();

        // Watchdog: m1 write never answered.
        drive_m(1, 1, 32'h400, CTI_CLASSIC);
        m_we[1] = 1;
        adv();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("wdog_err%0d", c), {o_m1_err[0], o_m0_err[0], o_s_cyc[0]},
                {c == 8, 1'b0, 1'b1});
            adv();
        end
        m_cyc[0] = 1; m_stb[0] = 1;
        for (int c = 9; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", c), {o_grant[0], o_s_cyc[0], o_m1_err[0]}, 0);
            adv();
        end
        drive_m(1, 0, 32'h0, CTI_CLASSIC);
        m_we[1] = 0;
        @(negedge clk); chk("drain_last", o_grant[0], 2'b00); adv();
        @(negedge clk); chk("drain_idle", o_grant[0], 2'b00); adv();
        @(negedge clk); chk("after_drain", o_grant[0], 2'b01); adv();
        drive_m(0, 0, 32'h0, CTI_CLASSIC);
        repeat (2) adv();

        // Reset during burst beat 2; contention right after reset.
        drive_m(0, 1, 32'h500, CTI_INC);
        adv();
        s_ack = 1; adv();
        rst = 1;
        @(negedge clk); chk("pre_rst_grant", o_grant[0], 2'b01); adv();
        rst = 0; s_ack = 0;
        m_cyc[1] = 1; m_stb[1] = 1;
        @(negedge clk);
        chk("post_rst_slave", {o_grant[0], o_s_cyc[0], o_s_stb[0], o_s_adr[0], o_s_cti[0]}, 0);
        adv();
        @(negedge clk); chk("post_rst_rr", {o_grant[0], o_grant[1]}, {2'b01, 2'b10}); adv();
        drive_m(0, 0, 0, 0); drive_m(1, 0, 0, 0);
        repeat (3) adv();

        // Randomized traffic checked by the reference model every cycle.
        for (int n = 0; n < 4000; n++) begin
            bit quiet;
            int r;
            quiet = ((n / 250) % 2) == 1;
            rst   = ($urandom_range(0, 599) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!m_cyc[m]) m_cyc[m] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 7) == 0) m_cyc[m] = 0;
                m_stb[m] = m_cyc[m] && ($urandom_range(0, 4) != 0);
                m_adr[m] = $urandom; m_dat[m] = $urandom; m_we[m] = $urandom_range(0, 1);
                m_sel[m] = 4'($urandom); m_cti[m] = 3'($urandom); m_bte[m] = 2'($urandom);
            end
            r = $urandom_range(0, quiet ? 29 : 5);
            s_ack = (r == 0) || (r == 1);
            s_err = (r == 2);
            s_rty = (r == 3);
            s_dat_i = $urandom;
            adv();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
